dvi_frame_reader: RTL
=====================

# dvi_frame_reader

Read-side client of the SSRAM controller's DVI port. On start it fetches one 640x480 frame from SSRAM (two 16-bit words per pixel) through that port, buffers pixels in a small FIFO and streams 24-bit RGB pixels to the DVI encoder over a valid/ready handshake. When the last pixel has been accepted downstream it pulses `o_dvi_finish`, which returns the controller's arbiter to IDLE.

## Interface
- `H_ACTIVE`, 640, pixels per line.
- `V_ACTIVE`, 480, lines per frame.
- `FIFO_DEPTH`, 8, pixel FIFO entries (power of two, ≥4).
- `clk`  in  1  single clock.
- `rst`  in  1  reset. Synchronous and active-high.
- `i_start`  in  1  one-cycle pulse that begins a frame read. Sampled only in IDLE.
- `o_dvi_sram_addr`  out  20  word address to the controller.
- `io_dvi_sram_data`  inout  16  read data from the controller. This block never drives it (always high-Z).
- `o_dvi_sram_we_n`  out  1  tied 1 (read-only client).
- `o_dvi_sram_oe_n`  out  1  read enable, active-low.
- `o_dvi_finish`  out  1  one-cycle pulse at end of frame.
- `o_pix_valid`  out  1  pixel available.
- `i_pix_ready`  in  1  downstream accepts the pixel.
- `o_pix_data`  out  24  pixel as {R[7:0], G[7:0], B[7:0]}.
- `o_pix_sof`  out  1  qualifies pixel 0 of the frame.
- `o_pix_eol`  out  1  qualifies the last pixel of each line (x == H_ACTIVE-1).
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- Pixel p occupies two words:
  - word 2p is {R, G};
  - word 2p+1 is {B, 8'hxx}, and the low byte is ignored.
- Frame spans word addresses 0 … 2·H_ACTIVE·V_ACTIVE−1 (614399 at the defaults).
- FSM states: IDLE, RD_W0, RD_W1, WAIT, DRAIN.
  - IDLE: `oe_n`=1, `addr`=0. On `i_start`, go to RD_W0 with `addr`=0 and `oe_n`=0.
  - RD_W0: capture `io_dvi_sram_data` into `hi_reg` at the clock edge, `addr`+1, go to RD_W1.
  - RD_W1: capture the low word, push {hi_reg[15:0], data[15:8]} with the sof/eol tags into the FIFO.
    - If this was the last pixel: go to DRAIN with `oe_n`=1.
    - Else, if the FIFO occupancy after this push equals FIFO_DEPTH: go to WAIT with `oe_n`=1.
    - Else: `addr`+1, go to RD_W0.
  - WAIT: `oe_n`=1, `addr` is held. When occupancy < FIFO_DEPTH, go to RD_W0 with `oe_n`=0.
  - DRAIN: stay until the FIFO is empty. Then pulse `o_dvi_finish` for 1 cycle and go to IDLE.
- Counters:
  - pixel counter 0 … H·V−1;
  - x counter 0 … H_ACTIVE−1, wrapping to 0 after eol.
  - Both clear on IDLE→RD_W0.
- FIFO: first-word fall-through. Push and pop in the same cycle leave occupancy unchanged. The FIFO never overflows; underflow is impossible because `o_pix_valid` = !empty.
- Handshake: a pixel transfers on `o_pix_valid & i_pix_ready`. `o_pix_data`, `o_pix_sof` and `o_pix_eol` are held stable while valid is high and ready is low.
- `i_start` outside IDLE is ignored.
- Reset mid-frame: the next cycle is IDLE, the FIFO is flushed, and all counters are cleared.

## Timing
- Reset values: `o_dvi_sram_addr`=0, `o_dvi_sram_oe_n`=1, `o_dvi_sram_we_n`=1, `o_dvi_finish`=0, `o_pix_valid`=0, `o_pix_data`=0, `o_pix_sof`=0, `o_pix_eol`=0, `o_busy`=0.
- All outputs to the SSRAM port are registered.
- Read data for address A is valid combinationally during the cycle in which `o_dvi_sram_addr`==A with `oe_n`=0, and is sampled at the end of that cycle.
- Latency: with `i_start` high in cycle 0:
  - `addr` 0 is driven in cycle 1;
  - `addr` 1 is driven in cycle 2;
  - `o_pix_valid`=1 in cycle 3 with `o_pix_sof`=1.
- Throughput: 1 pixel per 2 cycles when unthrottled.
- The finish pulse occurs 1 cycle after the last pop empties the FIFO. `o_busy` falls in the same cycle as the pulse.

## Test plan
- Full frame, `i_pix_ready`=1, SRAM model returns word[a]=a[15:0]:
  - exactly 307200 pixels;
  - pixel p = {(2p)[15:0], (2p+1)[15:8]};
  - addresses 0…614399 each read once, in order;
  - one `o_dvi_finish` pulse.
- Tags: `o_pix_sof` only on pixel 0; `o_pix_eol` on pixels 639, 1279, …, 307199 (480 pulses total).
- Backpressure, `i_pix_ready` low for 40 cycles after pixel 3:
  - FIFO holds 8;
  - FSM enters WAIT with `oe_n`=1;
  - no address skipped;
  - data stable during the stall;
  - the stream resumes intact.
- Random `i_pix_ready` (50%) over 2 frames: pixel sequence matches the model, no duplicates or drops, finish pulses after each frame's last accept.
- `rst` asserted at pixel 1000:
  - next cycle `oe_n`=1, `o_pix_valid`=0, `o_busy`=0;
  - a subsequent `i_start` restarts at `addr` 0 with sof.
- `i_start` pulsed while busy: ignored, with no address restart; `i_start` on the cycle after finish begins a new frame.

Source files
------------

// File: rtl/dvi_frame_reader.sv
// Read-side SSRAM client: fetches one frame (two words per pixel) into a
// small FWFT FIFO and streams 24-bit RGB pixels downstream.
module dvi_frame_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  output logic [19:0] o_dvi_sram_addr,
  inout  logic [15:0] io_dvi_sram_data,
  output logic        o_dvi_sram_we_n,
  output logic        o_dvi_sram_oe_n,
  output logic        o_dvi_finish,
  output logic        o_pix_valid,
  input  logic        i_pix_ready,
  output logic [23:0] o_pix_data,
  output logic        o_pix_sof,
  output logic        o_pix_eol,
  output logic        o_busy
);

  localparam int NPIX = H_ACTIVE * V_ACTIVE;
  localparam int PW   = $clog2(NPIX);
  localparam int XW   = $clog2(H_ACTIVE);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD_W0 = 3'd1;
  localparam logic [2:0] RD_W1 = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
  localparam logic [XW-1:0] LAST_X   = XW'(H_ACTIVE - 1);

  logic [2:0]    state;
  logic [19:0]   addr;
  logic          oe_n;
  logic          finish;
  logic [15:0]   hi_reg;
  logic [PW-1:0] pix_cnt;
  logic [XW-1:0] x_cnt;

  // Entry layout: {sof, eol, R, G, B}
  logic [25:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [25:0]   head;

  logic push;
  logic pop;
  logic sof_tag;
  logic eol_tag;
  logic last_pix;

  assign push     = (state == RD_W1);
  assign pop      = o_pix_valid & i_pix_ready;
  assign sof_tag  = (pix_cnt == '0);
  assign eol_tag  = (x_cnt == LAST_X);
  assign last_pix = (pix_cnt == LAST_PIX);

  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {sof_tag, eol_tag, hi_reg, io_dvi_sram_data[15:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr    <= '0;
      oe_n    <= 1'b1;
      finish  <= 1'b0;
      hi_reg  <= '0;
      pix_cnt <= '0;
      x_cnt   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      finish <= 1'b0;
      count  <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case (state)
        IDLE: begin
          oe_n <= 1'b1;
          addr <= '0;
          if (i_start) begin
            state   <= RD_W0;
            oe_n    <= 1'b0;
            pix_cnt <= '0;
            x_cnt   <= '0;
          end
        end
        RD_W0: begin
          hi_reg <= io_dvi_sram_data;
          addr   <= addr + 20'd1;
          state  <= RD_W1;
        end
        RD_W1: begin
          x_cnt <= eol_tag ? '0 : x_cnt + 1'b1;
          if (last_pix) begin
            state <= DRAIN;
            oe_n  <= 1'b1;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
            // Address advances here even when pausing, so WAIT holds the
            // next unread word rather than re-reading the current one.
            addr <= addr + 20'd1;
            if (count_next == FULL) begin
              state <= WAIT;
              oe_n  <= 1'b1;
            end else begin
              state <= RD_W0;
            end
          end
        end
        WAIT: begin
          if (count < FULL) begin
            state <= RD_W0;
            oe_n  <= 1'b0;
          end
        end
        DRAIN: begin
          if (count_next == '0) begin
            state  <= IDLE;
            finish <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign head            = mem[rd_ptr];
  assign o_pix_valid     = (count != '0);
  assign o_pix_data      = o_pix_valid ? head[23:0] : '0;
  assign o_pix_sof       = o_pix_valid & head[25];
  assign o_pix_eol       = o_pix_valid & head[24];
  assign o_dvi_sram_addr = addr;
  assign o_dvi_sram_oe_n = oe_n;
  assign o_dvi_sram_we_n = 1'b1;
  assign o_dvi_finish    = finish;
  assign o_busy          = (state != IDLE);

endmodule
